// File: rtl/output_sequencer.sv
// output_sequencer: framed-command controller for the LED output stage.
// A two-byte parser (opcode, operand) feeds a one-cycle execute stage that
// owns the output/enable shadows, the power-up ordering FSM
// (OFF -> SETTLE -> ON, plus TIMEOUT) and the host-silence watchdog.
module output_sequencer #(
    parameter int SETTLE_CYCLES   = 50,
    parameter int WATCHDOG_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       rx_frame_end,
    output logic [7:0] out,
    output logic [3:0] out_en,
    output logic       buffer_oe,
    output logic [2:0] status,
    output logic       frame_err
);

    localparam int SCW = $clog2(SETTLE_CYCLES + 1);
    localparam int WCW = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
    localparam logic [WCW-1:0] WD_LAST     = WCW'(WATCHDOG_CYCLES - 1);

    localparam logic [7:0] OP_SET_OUT = 8'h01;
    localparam logic [7:0] OP_SET_EN  = 8'h02;
    localparam logic [7:0] OP_ENABLE  = 8'h03;
    localparam logic [7:0] OP_DISABLE = 8'h04;

    typedef enum logic [1:0] {P_OP, P_ARG, P_DISCARD} parse_t;
    typedef enum logic [1:0] {PWR_OFF, PWR_SETTLE, PWR_ON, PWR_TIMEOUT} power_t;

    logic       run_reg;

    parse_t     parse_reg;
    logic [7:0] op_reg;
    logic       op_bad_reg;
    logic       extra_reg;
    logic       cmd_valid_reg;
    logic [7:0] cmd_op_reg;
    logic [7:0] cmd_arg_reg;
    logic       perr_reg;

    parse_t     parse_after;
    logic [7:0] op_after;
    logic       bad_after;
    logic       extra_after;
    logic       cmd_fire;
    logic       bad_fire;
    logic       close_err;

    power_t         power_reg;
    logic [SCW-1:0] settle_cnt_reg;
    logic [WCW-1:0] wd_cnt_reg;
    logic [7:0]     out_shadow_reg;
    logic [3:0]     en_shadow_reg;
    logic [7:0]     out_reg;
    logic [3:0]     out_en_reg;
    logic           buffer_oe_reg;
    logic           on_reg;
    logic           timeout_reg;
    logic           sticky_reg;
    logic           frame_err_reg;

    logic       kick;
    logic       do_enable;
    logic       do_disable;
    logic [7:0] out_shadow_next;
    logic [3:0] en_shadow_next;

    // Reset release flag: logic stays idle for the first edge after deassertion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) run_reg <= 1'b0;
        else        run_reg <= 1'b1;
    end

    // Byte consumption for this cycle; a coincident frame end is judged on the post-byte state.
    always_comb begin
        parse_after = parse_reg;
        op_after    = op_reg;
        bad_after   = op_bad_reg;
        extra_after = extra_reg;
        cmd_fire    = 1'b0;
        bad_fire    = 1'b0;
        if (rx_valid) begin
            case (parse_reg)
                P_OP: begin
                    parse_after = P_ARG;
                    op_after    = rx_byte;
                    bad_after   = (rx_byte > OP_DISABLE);
                    extra_after = 1'b0;
                end
                P_ARG: begin
                    parse_after = P_DISCARD;
                    cmd_fire    = !op_bad_reg;
                    bad_fire    = op_bad_reg;
                end
                default: extra_after = 1'b1;
            endcase
        end
        // A bad-opcode frame has already been reported, so trailing bytes add nothing.
        close_err = rx_frame_end &&
                    ((parse_after == P_ARG) || (extra_after && !bad_after));
    end

    // Parser registers: hands a complete command or an error strobe to the execute stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parse_reg     <= P_OP;
            op_reg        <= 8'h00;
            op_bad_reg    <= 1'b0;
            extra_reg     <= 1'b0;
            cmd_valid_reg <= 1'b0;
            cmd_op_reg    <= 8'h00;
            cmd_arg_reg   <= 8'h00;
            perr_reg      <= 1'b0;
        end else if (run_reg) begin
            parse_reg     <= rx_frame_end ? P_OP : parse_after;
            op_reg        <= op_after;
            op_bad_reg    <= bad_after;
            extra_reg     <= extra_after;
            cmd_valid_reg <= cmd_fire;
            perr_reg      <= bad_fire || close_err;
            if (cmd_fire) begin
                cmd_op_reg  <= op_reg;
                cmd_arg_reg <= rx_byte;
            end
        end
    end

    // Command decode and shadow update values for the execute edge.
    always_comb begin
        kick            = cmd_valid_reg;
        do_enable       = cmd_valid_reg && (cmd_op_reg == OP_ENABLE);
        do_disable      = cmd_valid_reg && (cmd_op_reg == OP_DISABLE);
        out_shadow_next = out_shadow_reg;
        en_shadow_next  = en_shadow_reg;
        if (cmd_valid_reg && (cmd_op_reg == OP_SET_OUT)) out_shadow_next = cmd_arg_reg;
        if (cmd_valid_reg && (cmd_op_reg == OP_SET_EN))  en_shadow_next  = cmd_arg_reg[3:0];
    end

    // Power FSM with registered outputs, settle timer, watchdog and error status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            power_reg      <= PWR_OFF;
            settle_cnt_reg <= '0;
            wd_cnt_reg     <= '0;
            out_shadow_reg <= 8'h00;
            en_shadow_reg  <= 4'h0;
            out_reg        <= 8'h00;
            out_en_reg     <= 4'h0;
            buffer_oe_reg  <= 1'b0;
            on_reg         <= 1'b0;
            timeout_reg    <= 1'b0;
            sticky_reg     <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else if (run_reg) begin
            frame_err_reg  <= perr_reg;
            out_shadow_reg <= out_shadow_next;
            en_shadow_reg  <= en_shadow_next;
            if (perr_reg)           sticky_reg <= 1'b1;
            else if (cmd_valid_reg) sticky_reg <= 1'b0;

            case (power_reg)
                PWR_SETTLE, PWR_ON: begin
                    if (do_disable) begin
                        power_reg      <= PWR_OFF;
                        buffer_oe_reg  <= 1'b0;
                        out_reg        <= 8'h00;
                        out_en_reg     <= 4'h0;
                        on_reg         <= 1'b0;
                        wd_cnt_reg     <= '0;
                        settle_cnt_reg <= '0;
                    end else if (!kick && (wd_cnt_reg == WD_LAST)) begin
                        power_reg      <= PWR_TIMEOUT;
                        buffer_oe_reg  <= 1'b0;
                        out_reg        <= 8'h00;
                        out_en_reg     <= 4'h0;
                        on_reg         <= 1'b0;
                        timeout_reg    <= 1'b1;
                        wd_cnt_reg     <= '0;
                        settle_cnt_reg <= '0;
                    end else begin
                        wd_cnt_reg <= kick ? '0 : wd_cnt_reg + WCW'(1);
                        if ((power_reg == PWR_ON) || (settle_cnt_reg == SETTLE_LAST)) begin
                            power_reg      <= PWR_ON;
                            on_reg         <= 1'b1;
                            out_reg        <= out_shadow_next;
                            out_en_reg     <= en_shadow_next;
                            settle_cnt_reg <= '0;
                        end else begin
                            settle_cnt_reg <= settle_cnt_reg + SCW'(1);
                        end
                    end
                end
                default: begin
                    // OFF and TIMEOUT keep the stage dark; only ENABLE starts a power-up.
                    wd_cnt_reg     <= '0;
                    settle_cnt_reg <= '0;
                    out_reg        <= 8'h00;
                    out_en_reg     <= 4'h0;
                    if (do_enable) begin
                        power_reg     <= PWR_SETTLE;
                        buffer_oe_reg <= 1'b1;
                        timeout_reg   <= 1'b0;
                    end else if (do_disable) begin
                        power_reg   <= PWR_OFF;
                        timeout_reg <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign out       = out_reg;
    assign out_en    = out_en_reg;
    assign buffer_oe = buffer_oe_reg;
    assign status    = {sticky_reg, timeout_reg, on_reg};
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_output_sequencer.sv
// Directed bench for output_sequencer with SETTLE_CYCLES=4, WATCHDOG_CYCLES=100.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_output_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_frame_end;
    logic [7:0] out;
    logic [3:0] out_en;
    logic       buffer_oe;
    logic [2:0] status;
    logic       frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    output_sequencer #(
        .SETTLE_CYCLES   (4),
        .WATCHDOG_CYCLES (100)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .rx_frame_end (rx_frame_end),
        .out          (out),
        .out_en       (out_en),
        .buffer_oe    (buffer_oe),
        .status       (status),
        .frame_err    (frame_err)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] e_out, input logic [3:0] e_en,
                             input logic e_oe, input logic [2:0] e_st, input logic e_fe);
        check({tag, ".out"},       out,                 e_out);
        check({tag, ".out_en"},    {4'h0, out_en},      {4'h0, e_en});
        check({tag, ".buffer_oe"}, {7'h00, buffer_oe},  {7'h00, e_oe});
        check({tag, ".status"},    {5'h00, status},     {5'h00, e_st});
        check({tag, ".frame_err"}, {7'h00, frame_err},  {7'h00, e_fe});
    endtask

    task automatic strobe(input logic v, input logic [7:0] b, input logic fe);
        rx_valid     = v;
        rx_byte      = b;
        rx_frame_end = fe;
        @(negedge clk);
        rx_valid     = 1'b0;
        rx_byte      = 8'h00;
        rx_frame_end = 1'b0;
    endtask

    // Opcode byte, then operand byte coincident with the frame end.
    task automatic send2(input logic [7:0] op, input logic [7:0] arg);
        strobe(1'b1, op, 1'b0);
        strobe(1'b1, arg, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        reset        = 1'b0;
        rx_valid     = 1'b0;
        rx_byte      = 8'h00;
        rx_frame_end = 1'b0;
        idle(3);
        check_all("reset", 8'h00, 4'h0, 1'b0, 3'b000, 1'b0);
        reset = 1'b1;
        idle(1);

        // Shadows loaded while OFF stay hidden until ON.
        send2(8'h01, 8'h3C);
        send2(8'h02, 8'h05);
        check_all("preload_off", 8'h00, 4'h0, 1'b0, 3'b000, 1'b0);
        send2(8'h03, 8'h00);
        check_all("enable_sample_edge", 8'h00, 4'h0, 1'b0, 3'b000, 1'b0);
        idle(1);
        check_all("settle_start", 8'h00, 4'h0, 1'b1, 3'b000, 1'b0);
        idle(3);
        check_all("settle_last", 8'h00, 4'h0, 1'b1, 3'b000, 1'b0);
        idle(1);
        check_all("on_entry", 8'h3C, 4'h5, 1'b1, 3'b001, 1'b0);

        // Live updates in ON appear one edge after the operand edge.
        send2(8'h02, 8'h0F);
        check_all("set_en_before", 8'h3C, 4'h5, 1'b1, 3'b001, 1'b0);
        idle(1);
        check_all("set_en", 8'h3C, 4'hF, 1'b1, 3'b001, 1'b0);
        send2(8'h01, 8'hA5);
        check_all("set_out_before", 8'h3C, 4'hF, 1'b1, 3'b001, 1'b0);
        idle(1);
        check_all("set_out", 8'hA5, 4'hF, 1'b1, 3'b001, 1'b0);

        // Watchdog: NOP executes 99 edges after the last kick, then expiry 100 edges later.
        idle(96);
        send2(8'h00, 8'h00);
        idle(100);
        check_all("wd_kicked", 8'hA5, 4'hF, 1'b1, 3'b001, 1'b0);
        idle(1);
        check_all("wd_expired", 8'h00, 4'h0, 1'b0, 3'b010, 1'b0);

        // Recovery from TIMEOUT keeps the shadows.
        send2(8'h03, 8'h00);
        idle(1);
        check_all("re_enable", 8'h00, 4'h0, 1'b1, 3'b000, 1'b0);
        idle(4);
        check_all("retained", 8'hA5, 4'hF, 1'b1, 3'b001, 1'b0);

        // Frame ended after opcode only.
        strobe(1'b1, 8'h01, 1'b0);
        strobe(1'b0, 8'h00, 1'b1);
        check_all("short_pre", 8'hA5, 4'hF, 1'b1, 3'b001, 1'b0);
        idle(1);
        check_all("short_err", 8'hA5, 4'hF, 1'b1, 3'b101, 1'b1);
        idle(1);
        check_all("short_after", 8'hA5, 4'hF, 1'b1, 3'b101, 1'b0);

        // Three-byte frame: command runs, trailing byte flags at frame end.
        strobe(1'b1, 8'h01, 1'b0);
        strobe(1'b1, 8'h11, 1'b0);
        strobe(1'b1, 8'h22, 1'b1);
        check_all("long_exec", 8'h11, 4'hF, 1'b1, 3'b001, 1'b0);
        idle(1);
        check_all("long_err", 8'h11, 4'hF, 1'b1, 3'b101, 1'b1);

        // Unknown opcode flags at the operand byte.
        send2(8'h7F, 8'h00);
        check_all("badop_pre", 8'h11, 4'hF, 1'b1, 3'b101, 1'b0);
        idle(1);
        check_all("badop_err", 8'h11, 4'hF, 1'b1, 3'b101, 1'b1);

        send2(8'h00, 8'h00);
        idle(1);
        check_all("nop_clears", 8'h11, 4'hF, 1'b1, 3'b001, 1'b0);

        // Operand 0x00 with coincident frame end executes cleanly.
        send2(8'h01, 8'h00);
        idle(1);
        check_all("coincident", 8'h00, 4'hF, 1'b1, 3'b001, 1'b0);
        idle(1);
        check("coincident_no_err", {7'h00, frame_err}, 8'h00);

        // Async reset mid-SETTLE and mid-frame.
        send2(8'h04, 8'h00);
        idle(1);
        check_all("disable", 8'h00, 4'h0, 1'b0, 3'b000, 1'b0);
        send2(8'h03, 8'h00);
        idle(1);
        check_all("settle_again", 8'h00, 4'h0, 1'b1, 3'b000, 1'b0);
        strobe(1'b1, 8'h01, 1'b0);
        reset = 1'b0;
        #1;
        check_all("async_reset", 8'h00, 4'h0, 1'b0, 3'b000, 1'b0);
        idle(2);
        reset = 1'b1;
        idle(1);
        send2(8'h03, 8'h00);
        idle(1);
        check_all("post_reset_enable", 8'h00, 4'h0, 1'b1, 3'b000, 1'b0);
        idle(4);
        check_all("post_reset_on", 8'h00, 4'h0, 1'b1, 3'b001, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/output_sequencer.md
# output_sequencer

Command-driven controller sequencing the LED output stage behind the SPI receive path. Accepts framed command bytes from the SPI shift logic, and owns the 8-bit output bus, the differential-driver enables and the 3v3→5v translator enable. Enforces power-up ordering (translator, settle, drivers) and uses a watchdog that blanks all outputs if the host stops talking.

## Interface
- SETTLE_CYCLES, 50: clk cycles between buffer_oe rising and out_en being driven (1 µs at 50 MHz); ≥1.
- WATCHDOG_CYCLES, 5000000: clk cycles without a valid command before outputs are forced off (100 ms); ≥2.
- clk  in  1  master clock, 50 MHz.
- reset  in  1  active-low reset, asynchronous assert; one clock.
- rx_valid  in  1  one-cycle strobe, rx_byte holds a received byte.
- rx_byte  in  8  received byte, MSB first on the wire.
- rx_frame_end  in  1  one-cycle strobe, chip select deasserted.
- out  out  8  output data bus.
- out_en  out  4  differential driver enables.
- buffer_oe  out  1  level translator enable.
- status  out  3  [0] ON, [1] TIMEOUT, [2] sticky frame error.
- frame_err  out  1  one-cycle pulse per malformed frame.

## Operation
- Frame = exactly 2 bytes: opcode, operand. Opcodes: 0x00 NOP, 0x01 SET_OUT (operand→out_shadow), 0x02 SET_EN (operand[3:0]→en_shadow, [7:4] ignored), 0x03 ENABLE, 0x04 DISABLE. Other opcodes: no action, frame error.
- Parser states: P_OP → (rx_valid) P_ARG → (rx_valid, execute) P_DISCARD; further bytes ignored. rx_frame_end from any state → P_OP. Frame ended in P_ARG, extra bytes in P_DISCARD, or bad opcode → frame_err pulse at frame end (bad opcode: at operand byte); status[2] set.
- Valid command (incl. NOP) clears status[2] and the watchdog counter.
- Same-cycle rx_valid and rx_frame_end: byte consumed first, then frame closed.
- Power FSM:
  - OFF: buffer_oe=0, out_en=0, out=0. ENABLE → SETTLE.
  - SETTLE: buffer_oe=1, out_en=0, out=0; counter runs SETTLE_CYCLES, then → ON.
  - ON: buffer_oe=1, out_en=en_shadow, out=out_shadow.
  - TIMEOUT: as OFF, status[1]=1; only ENABLE → SETTLE.
- DISABLE from SETTLE/ON/TIMEOUT → OFF. ENABLE in SETTLE/ON: no restart, watchdog kick only.
- Shadows are written in every state and retained across OFF/TIMEOUT; applied on entry to ON.
- Watchdog counts only in SETTLE and ON, width clog2(WATCHDOG_CYCLES+1); reaching WATCHDOG_CYCLES-1 → TIMEOUT, counter cleared. Kick wins over expiry in the same cycle.

## Timing
- Reset (asynchronous): out=0, out_en=0, buffer_oe=0, status=0, frame_err=0, shadows=0, power=OFF, parser=P_OP, counters=0. Release synchronised; first command accepted on the 2nd edge after deassertion.
- All outputs registered. Operand byte sampled at edge N; state/shadow update and output change at edge N+1.
- ENABLE executed at edge E: buffer_oe=1 at E; out_en/out valid at E+SETTLE_CYCLES.
- SET_OUT/SET_EN in ON: visible at edge N+1; no glitch on unchanged bits.
- Watchdog: last kick at edge K → outputs forced 0 at edge K+WATCHDOG_CYCLES.
- frame_err is exactly one cycle, one edge after the causing strobe.

## Test plan
- Reset, then {0x03,0x00}, {0x02,0x0F}, {0x01,0xA5} with SETTLE_CYCLES=4 -> buffer_oe=1 one edge after ENABLE, out_en=0xF and out=0xA5 four edges later, status=3'b001.
- Shadows pre-loaded in OFF ({0x01,0x3C}, {0x02,0x05}) then ENABLE -> out stays 0x00 until ON, then out=0x3C, out_en=0x5.
- WATCHDOG_CYCLES=100, ON, no traffic -> out=0, out_en=0, buffer_oe=0, status=3'b010 100 cycles after last kick; NOP at cycle 99 prevents it.
- Frames {0x01} only, {0x01,0x11,0x22}, {0x7F,0x00} -> three frame_err pulses, status[2]=1, out unchanged except 0x11 from 2nd frame; next valid NOP clears status[2].
- Reset asserted mid-SETTLE and mid-frame -> all outputs 0 immediately (async), a subsequent opcode byte is parsed as an opcode.
- rx_valid with 0x00 coincident with rx_frame_end in P_ARG -> command executes, no frame_err.
